washing_machine_seq: RTL and testbench
======================================

WASHING_MACHINE_SEQ -- requirements
Module: washing_machine_seq

Interface
REQ-001 SHALL have parameter RC_W, default 2, width of rinse_count; the maximum rinse repeats is 2**RC_W-1.
REQ-002 SHALL have parameter TMO_W, default 16, phase timeout counter width.
REQ-003 SHALL have parameter TIMEOUT, default 1000, cycles allowed per phase; legal range 2 to 2**TMO_W-1.
REQ-004 SHALL have one clock, `clk`, and `reset`, which is asynchronous and active-high.
REQ-005 `clk`  in  1  rising-edge clock.
REQ-006 `reset`  in  1  asynchronous active-high reset.
REQ-007 `start`  in  1  begin cycle; sampled in IDLE only.
REQ-008 `door_locked`  in  1  door latch confirmed.
REQ-009 `fill_done` / `wash_done` / `rinse_done` / `spin_done` / `drain_done` / `dry_done`  in  1 each  phase-complete levels.
REQ-010 `pause`  in  1  pause request.
REQ-011 `resume`  in  1  resume request.
REQ-012 `abort`  in  1  cancel cycle or clear fault.
REQ-013 `rinse_count`  in  RC_W  number of rinse passes; latched at start.
REQ-014 `dry_en`  in  1  include dry phase; latched at start.
REQ-015 `lock_door`, `fill_water`, `wash`, `rinse`, `spin`, `drain`, `dry`  out  1 each  actuator commands.
REQ-016 `busy`  out  1  high in any state except IDLE.
REQ-017 `paused`  out  1  high in PAUSED.
REQ-018 `done`  out  1  one-cycle completion pulse.
REQ-019 `fault`  out  1  high in FAULT.
REQ-020 `state`  out  4  current state encoding.

Function
REQ-021 States and encodings SHALL be: IDLE=0, LOCK=1, FILL=2, WASH=3, DRAIN=4, RINSE=5, SPIN=6, DRY=7, DONE=8, PAUSED=9, FAULT=10.
REQ-022 All outputs SHALL decode from registered state only; there is no combinational input-to-output path.
REQ-023 Actuator per state: LOCK lock_door; FILL fill_water; WASH wash; DRAIN drain; RINSE rinse; SPIN spin; DRY dry; FAULT drain. lock_door SHALL be 1 in every state from LOCK through DONE, and in PAUSED and FAULT; all other actuators are 0.
REQ-024 IDLE: when start=1, the FSM SHALL go to LOCK on the same edge and latch rinse_count and dry_en, and the rinse counter SHALL clear to 0.
REQ-025 Transitions SHALL be: LOCK->FILL on door_locked, FILL->WASH on fill_done, and WASH->DRAIN on wash_done.
REQ-026 DRAIN on drain_done SHALL go to RINSE if the rinse counter is less than the latched count, else to SPIN; RINSE on rinse_done SHALL increment the counter and go to DRAIN.
REQ-027 With a latched count of 0, DRAIN SHALL go directly to SPIN after the wash drain.
REQ-028 SPIN on spin_done SHALL go to DRY if dry_en is latched, else to DONE; DRY on dry_done SHALL go to DONE.
REQ-029 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-030 Timeout: the counter SHALL clear on every state entry and, per edge in LOCK..DRY without that state's done, either go to FAULT if count==TIMEOUT-1 or increment; FAULT is therefore reached on the TIMEOUT-th edge after entry.
REQ-031 Pause: pause=1 in FILL..DRY SHALL go to PAUSED, save the return state, turn off actuators except lock_door, and hold the timeout counter.
REQ-032 Pause SHALL be ignored in LOCK, IDLE, DONE and FAULT.
REQ-033 PAUSED: resume=1 SHALL return to the saved state with the counter unchanged; phase-done inputs SHALL be ignored while paused; pause and resume together SHALL resolve as resume.
REQ-034 Priority within a cycle SHALL be abort > timeout > phase done > pause.
REQ-035 A phase done coinciding with pause SHALL advance to the next state; the held pause then takes effect on the next edge.
REQ-036 abort=1 in any non-IDLE state SHALL go to IDLE next edge with no done pulse; this is the only exit from FAULT other than reset.
REQ-037 Start, or a done input asserted in a non-matching state, SHALL be ignored.

Reset
REQ-038 Reset=1 SHALL immediately, without a clock edge, force IDLE; all outputs 0; timeout counter, rinse counter, latched config and saved state 0.
REQ-039 Reset asserted mid-phase SHALL abandon the cycle; after release the FSM waits in IDLE for start.

Verification
REQ-040 rinse_count=2, dry_en=1, each done pulsed 3 cycles after entry -> states 0,1,2,3,4,5,4,5,4,6,7,8,0; done high exactly one cycle; one actuator per REQ-023.
REQ-041 rinse_count=0, dry_en=0 -> WASH,DRAIN,SPIN,DONE,IDLE; rinse and dry never asserted.
REQ-042 TIMEOUT=16, pause in WASH at count 10 held 40 cycles, then resume -> no fault, paused=1, actuators 0, lock_door=1; back in WASH, FAULT 6 edges later if wash_done withheld.
REQ-043 TIMEOUT=16, fill_done withheld -> FAULT on 16th edge after FILL entry, fault=1, drain=1, lock_door=1; abort -> IDLE, outputs 0.
REQ-044 wash_done and pause in the same cycle -> DRAIN, then PAUSED next edge; resume -> DRAIN, drain=1.
REQ-045 Reset asserted between edges during SPIN -> all outputs 0 and state=0 before the next clk edge.

Source files
------------

// File: rtl/washing_machine_seq.sv
// Washing machine cycle sequencer: lock, fill, wash, rinse passes, spin, dry.
// Per-phase timeout, pause/resume with a saved return state, and an abortable fault state.
module washing_machine_seq #(
    parameter int RC_W    = 2,
    parameter int TMO_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            door_locked,
    input  logic            fill_done,
    input  logic            wash_done,
    input  logic            rinse_done,
    input  logic            spin_done,
    input  logic            drain_done,
    input  logic            dry_done,
    input  logic            pause,
    input  logic            resume,
    input  logic            abort,
    input  logic [RC_W-1:0] rinse_count,
    input  logic            dry_en,
    output logic            lock_door,
    output logic            fill_water,
    output logic            wash,
    output logic            rinse,
    output logic            spin,
    output logic            drain,
    output logic            dry,
    output logic            busy,
    output logic            paused,
    output logic            done,
    output logic            fault,
    output logic [3:0]      state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOCK   = 4'd1,
        S_FILL   = 4'd2,
        S_WASH   = 4'd3,
        S_DRAIN  = 4'd4,
        S_RINSE  = 4'd5,
        S_SPIN   = 4'd6,
        S_DRY    = 4'd7,
        S_DONE   = 4'd8,
        S_PAUSED = 4'd9,
        S_FAULT  = 4'd10
    } state_t;

    state_t            state_q, state_d;
    state_t            saved_q, saved_d;
    state_t            pnext;
    logic [TMO_W-1:0]  cnt_q, cnt_d;
    logic [RC_W-1:0]   rc_q, rc_d;
    logic [RC_W-1:0]   rinse_q, rinse_d;
    logic              dry_q, dry_d;
    logic              pdone;
    logic              tmo;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            saved_q <= S_IDLE;
            cnt_q   <= '0;
            rc_q    <= '0;
            rinse_q <= '0;
            dry_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            cnt_q   <= cnt_d;
            rc_q    <= rc_d;
            rinse_q <= rinse_d;
            dry_q   <= dry_d;
        end
    end

    // Completion input and successor for the current phase
    always_comb begin
        pdone = 1'b0;
        pnext = state_q;
        case (state_q)
            S_LOCK: begin
                pdone = door_locked;
                pnext = S_FILL;
            end
            S_FILL: begin
                pdone = fill_done;
                pnext = S_WASH;
            end
            S_WASH: begin
                pdone = wash_done;
                pnext = S_DRAIN;
            end
            S_DRAIN: begin
                pdone = drain_done;
                pnext = (rinse_q < rc_q) ? S_RINSE : S_SPIN;
            end
            S_RINSE: begin
                pdone = rinse_done;
                pnext = S_DRAIN;
            end
            S_SPIN: begin
                pdone = spin_done;
                pnext = dry_q ? S_DRY : S_DONE;
            end
            S_DRY: begin
                pdone = dry_done;
                pnext = S_DONE;
            end
            default: begin
                pdone = 1'b0;
                pnext = state_q;
            end
        endcase
    end

    assign tmo = (cnt_q == TMO_W'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        saved_d = saved_q;
        rc_d    = rc_q;
        rinse_d = rinse_q;
        dry_d   = dry_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOCK;
                    rc_d    = rinse_count;
                    dry_d   = dry_en;
                    rinse_d = '0;
                end
            end
            S_DONE:   state_d = S_IDLE;
            S_PAUSED: begin
                if (abort)
                    state_d = S_IDLE;
                else if (resume)
                    state_d = saved_q;
            end
            S_FAULT: begin
                if (abort)
                    state_d = S_IDLE;
            end
            default: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (tmo) begin
                    state_d = S_FAULT;
                end else if (pdone) begin
                    state_d = pnext;
                    if (state_q == S_RINSE)
                        rinse_d = rinse_q + 1'b1;
                end else if (pause && state_q != S_LOCK) begin
                    state_d = S_PAUSED;
                    saved_d = state_q;
                end
            end
        endcase
    end

    // Timeout count survives the trip into and back out of PAUSED
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            if (state_d == S_PAUSED
                || (state_q == S_PAUSED && state_d != S_IDLE))
                cnt_d = cnt_q;
            else
                cnt_d = '0;
        end else if (state_q >= S_LOCK && state_q <= S_DRY) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign lock_door  = (state_q != S_IDLE);
    assign fill_water = (state_q == S_FILL);
    assign wash       = (state_q == S_WASH);
    assign rinse      = (state_q == S_RINSE);
    assign spin       = (state_q == S_SPIN);
    assign drain      = (state_q == S_DRAIN) || (state_q == S_FAULT);
    assign dry        = (state_q == S_DRY);
    assign busy       = (state_q != S_IDLE);
    assign paused     = (state_q == S_PAUSED);
    assign done       = (state_q == S_DONE);
    assign fault      = (state_q == S_FAULT);
    assign state      = state_q;

endmodule

// File: tb/tb_washing_machine_seq.sv
// Directed bench for washing_machine_seq with TIMEOUT=16.
// Checks sequencing, rinse loop, pause/resume, timeout fault, abort and async reset.
module tb_washing_machine_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       pause;
    logic       resume;
    logic       abort;
    logic [1:0] rinse_count;
    logic       dry_en;
    // 0 fill, 1 wash, 2 rinse, 3 spin, 4 drain, 5 dry, 6 door_locked
    logic [6:0] dn;
    logic       lock_door, fill_water, wash, rinse, spin, drain, dry;
    logic       busy, paused, done, fault;
    logic [3:0] state;
    logic [10:0] outs;

    int checks = 0;
    int errors = 0;

    washing_machine_seq #(
        .RC_W(2),
        .TMO_W(16),
        .TIMEOUT(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .door_locked(dn[6]),
        .fill_done(dn[0]),
        .wash_done(dn[1]),
        .rinse_done(dn[2]),
        .spin_done(dn[3]),
        .drain_done(dn[4]),
        .dry_done(dn[5]),
        .pause(pause),
        .resume(resume),
        .abort(abort),
        .rinse_count(rinse_count),
        .dry_en(dry_en),
        .lock_door(lock_door),
        .fill_water(fill_water),
        .wash(wash),
        .rinse(rinse),
        .spin(spin),
        .drain(drain),
        .dry(dry),
        .busy(busy),
        .paused(paused),
        .done(done),
        .fault(fault),
        .state(state)
    );

    always #5 clk = ~clk;

    assign outs = {lock_door, fill_water, wash, rinse, spin, drain, dry,
                   busy, paused, done, fault};

    // {lock,fill,wash,rinse,spin,drain,dry,busy,paused,done,fault}
    function automatic logic [10:0] exp_out(input int st);
        case (st)
            0:       return 11'b000_0000_0000;
            1:       return 11'b100_0000_1000;
            2:       return 11'b110_0000_1000;
            3:       return 11'b101_0000_1000;
            4:       return 11'b100_0010_1000;
            5:       return 11'b100_1000_1000;
            6:       return 11'b100_0100_1000;
            7:       return 11'b100_0001_1000;
            8:       return 11'b100_0000_1010;
            9:       return 11'b100_0000_1100;
            10:      return 11'b100_0010_1001;
            default: return 11'b111_1111_1111;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_st(input string tag, input int st);
        chk({tag, ".state"}, {28'd0, state}, st);
        chk({tag, ".outs"}, {21'd0, outs}, {21'd0, exp_out(st)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check phase on entry, then pulse its done so it is seen 3 edges after entry
    task automatic phase(input string tag, input int st, input int idx);
        chk_st(tag, st);
        tick();
        tick();
        dn[idx] = 1'b1;
        tick();
        dn = '0;
    endtask

    task automatic begin_cycle(input logic [1:0] rc, input logic de);
        rinse_count = rc;
        dry_en = de;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        pause = 1'b0;
        resume = 1'b0;
        abort = 1'b0;
        rinse_count = '0;
        dry_en = 1'b0;
        dn = '0;
        #1;
        chk_st("reset", 0);
        tick();
        reset = 1'b0;
        tick();

        // Done inputs in IDLE are ignored
        dn = 7'h7F;
        tick();
        dn = '0;
        chk_st("idle_ignore", 0);

        // Full cycle: two rinses plus dry
        begin_cycle(2'd2, 1'b1);
        phase("f_lock", 1, 6);
        phase("f_fill", 2, 0);
        phase("f_wash", 3, 1);
        phase("f_drain0", 4, 4);
        phase("f_rinse0", 5, 2);
        phase("f_drain1", 4, 4);
        phase("f_rinse1", 5, 2);
        phase("f_drain2", 4, 4);
        phase("f_spin", 6, 3);
        phase("f_dry", 7, 5);
        chk_st("f_done", 8);
        tick();
        chk_st("f_idle", 0);

        // Short cycle, no rinse, no dry; pause ignored in LOCK
        begin_cycle(2'd0, 1'b0);
        pause = 1'b1;
        tick();
        pause = 1'b0;
        chk_st("s_lock_pause", 1);
        phase("s_lock", 1, 6);
        phase("s_fill", 2, 0);
        phase("s_wash", 3, 1);
        phase("s_drain", 4, 4);
        phase("s_spin", 6, 3);
        chk_st("s_done", 8);
        tick();
        chk_st("s_idle", 0);

        // Timeout in FILL
        begin_cycle(2'd0, 1'b0);
        phase("t_lock", 1, 6);
        chk_st("t_fill", 2);
        repeat (15) tick();
        chk_st("t_fill15", 2);
        tick();
        chk_st("t_fault", 10);
        tick();
        chk_st("t_fault_hold", 10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_st("t_abort", 0);

        // Pause in WASH at count 10, hold 40 cycles, resume, then timeout
        begin_cycle(2'd0, 1'b0);
        phase("p_lock", 1, 6);
        phase("p_fill", 2, 0);
        chk_st("p_wash", 3);
        repeat (10) tick();
        pause = 1'b1;
        tick();
        chk_st("p_paused", 9);
        repeat (20) tick();
        dn[1] = 1'b1;
        tick();
        dn = '0;
        repeat (18) tick();
        chk_st("p_paused40", 9);
        resume = 1'b1;
        tick();
        pause = 1'b0;
        resume = 1'b0;
        chk_st("p_resumed", 3);
        repeat (5) tick();
        chk_st("p_wash15", 3);
        tick();
        chk_st("p_fault", 10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_st("p_abort", 0);

        // wash_done with pause in the same cycle
        begin_cycle(2'd0, 1'b0);
        phase("c_lock", 1, 6);
        phase("c_fill", 2, 0);
        chk_st("c_wash", 3);
        tick();
        tick();
        dn[1] = 1'b1;
        pause = 1'b1;
        tick();
        dn = '0;
        chk_st("c_drain", 4);
        tick();
        pause = 1'b0;
        chk_st("c_paused", 9);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk_st("c_resume", 4);
        phase("c_drain2", 4, 4);

        // Async reset between edges in SPIN
        chk_st("r_spin", 6);
        #2;
        reset = 1'b1;
        #1;
        chk_st("r_async", 0);
        tick();
        reset = 1'b0;
        tick();
        chk_st("r_idle", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
